// File: rtl/watch_pkg.sv
`default_nettype none
// ============================================================================
// Module  : watch_pkg
// Brief   : Shared watch types: edit FSM states, field widths/limits, edit_sel codes.
// Revision: 1.0
// ============================================================================
package watch_pkg;

    localparam int HOUR_W = 5;
    localparam int MIN_W  = 6;

    localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;
    localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;

    localparam logic [1:0] SEL_NONE = 2'd0;
    localparam logic [1:0] SEL_HOUR = 2'd1;
    localparam logic [1:0] SEL_MIN  = 2'd2;
    localparam logic [1:0] SEL_SEC  = 2'd3;

    typedef enum logic [2:0] {
        ST_RUN    = 3'd0,
        ST_EDIT_H = 3'd1,
        ST_EDIT_M = 3'd2,
        ST_EDIT_S = 3'd3,
        ST_COMMIT = 3'd4
    } state_t;

    // Out-of-range inputs snap back into range on their first step.
    function automatic logic [HOUR_W-1:0] hour_step(input logic [HOUR_W-1:0] v,
                                                    input logic up);
        if (up)
            return (v >= HOUR_MAX) ? 5'd0 : v + 5'd1;
        else
            return (v == 5'd0 || v > HOUR_MAX) ? HOUR_MAX : v - 5'd1;
    endfunction

    function automatic logic [MIN_W-1:0] min_step(input logic [MIN_W-1:0] v,
                                                  input logic up);
        if (up)
            return (v >= MIN_MAX) ? 6'd0 : v + 6'd1;
        else
            return (v == 6'd0 || v > MIN_MAX) ? MIN_MAX : v - 6'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module  : btn_debounce
// Brief   : 2-flop synchronizer + stable-count debouncer with rising-edge press pulse.
// Revision: 1.0
// ============================================================================
module btn_debounce #(
    parameter int DB_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;

    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        press_d = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                press_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule
`default_nettype wire

// File: rtl/time_set_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : time_set_ctrl
// Brief   : Button-driven time edit FSM with shadow H/M/S, commit load and field blink.
// Revision: 1.0
// ============================================================================
module time_set_ctrl
    import watch_pkg::*;
#(
    parameter int DB_CYCLES    = 500000,
    parameter int BLINK_CYCLES = 25000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_mode,
    input  logic              btn_up,
    input  logic              btn_down,
    input  logic [HOUR_W-1:0] cur_hour,
    input  logic [MIN_W-1:0]  cur_minute,
    input  logic [MIN_W-1:0]  cur_second,
    output logic [HOUR_W-1:0] set_hour,
    output logic [MIN_W-1:0]  set_minute,
    output logic [MIN_W-1:0]  set_second,
    output logic              load,
    output logic              hold,
    output logic [1:0]        edit_sel,
    output logic              blink_on
);

    localparam int BL_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_CYCLES - 1);

    logic mode_p, up_p, down_p;
    logic mode_level_unused, up_level_unused, down_level_unused;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_mode (
        .clk(clk), .rst(rst), .raw(btn_mode), .level(mode_level_unused), .press(mode_p));
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_up (
        .clk(clk), .rst(rst), .raw(btn_up), .level(up_level_unused), .press(up_p));
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_down (
        .clk(clk), .rst(rst), .raw(btn_down), .level(down_level_unused), .press(down_p));

    state_t            state_q, state_d;
    logic [HOUR_W-1:0] hour_q, hour_d;
    logic [MIN_W-1:0]  min_q, min_d;
    logic [MIN_W-1:0]  sec_q, sec_d;
    logic [BL_W-1:0]   blink_cnt_q, blink_cnt_d;
    logic              blink_on_q, blink_on_d;

    logic step_up, step_dn, step, in_edit;

    assign step_up = up_p & ~down_p;
    assign step_dn = down_p & ~up_p;
    assign step    = step_up | step_dn;
    assign in_edit = (state_q == ST_EDIT_H) || (state_q == ST_EDIT_M) || (state_q == ST_EDIT_S);

    always_comb begin
        state_d     = state_q;
        hour_d      = hour_q;
        min_d       = min_q;
        sec_d       = sec_q;
        blink_cnt_d = '0;
        blink_on_d  = 1'b1;

        if (in_edit) begin
            if (blink_cnt_q == BL_LAST) begin
                blink_on_d = ~blink_on_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
                blink_on_d  = blink_on_q;
            end
        end

        // Mode is checked first in every edit state so it overrides up/down.
        case (state_q)
            ST_RUN: begin
                if (mode_p) begin
                    hour_d  = cur_hour;
                    min_d   = cur_minute;
                    sec_d   = cur_second;
                    state_d = ST_EDIT_H;
                end
            end
            ST_EDIT_H: begin
                if (mode_p) begin
                    state_d     = ST_EDIT_M;
                    blink_cnt_d = '0;
                    blink_on_d  = 1'b1;
                end else if (step) begin
                    hour_d      = hour_step(hour_q, step_up);
                    blink_cnt_d = '0;
                    blink_on_d  = 1'b1;
                end
            end
            ST_EDIT_M: begin
                if (mode_p) begin
                    state_d     = ST_EDIT_S;
                    blink_cnt_d = '0;
                    blink_on_d  = 1'b1;
                end else if (step) begin
                    min_d       = min_step(min_q, step_up);
                    blink_cnt_d = '0;
                    blink_on_d  = 1'b1;
                end
            end
            ST_EDIT_S: begin
                if (mode_p) begin
                    state_d     = ST_COMMIT;
                    blink_cnt_d = '0;
                    blink_on_d  = 1'b1;
                end else if (step) begin
                    sec_d       = min_step(sec_q, step_up);
                    blink_cnt_d = '0;
                    blink_on_d  = 1'b1;
                end
            end
            ST_COMMIT: state_d = ST_RUN;
            default:   state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RUN;
            hour_q      <= '0;
            min_q       <= '0;
            sec_q       <= '0;
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            hour_q      <= hour_d;
            min_q       <= min_d;
            sec_q       <= sec_d;
            blink_cnt_q <= blink_cnt_d;
            blink_on_q  <= blink_on_d;
        end
    end

    always_comb begin
        case (state_q)
            ST_EDIT_H: edit_sel = SEL_HOUR;
            ST_EDIT_M: edit_sel = SEL_MIN;
            ST_EDIT_S: edit_sel = SEL_SEC;
            default:   edit_sel = SEL_NONE;
        endcase
    end

    assign hold       = in_edit || (state_q == ST_COMMIT);
    assign load       = (state_q == ST_COMMIT);
    assign blink_on   = blink_on_q;
    assign set_hour   = hour_q;
    assign set_minute = min_q;
    assign set_second = sec_q;

endmodule
`default_nettype wire

// File: tb/tb_time_set_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_time_set_ctrl
// Brief   : Scoreboard bench: expected output snapshots queued by stimulus, popped on change.
// Revision: 1.0
// ============================================================================
module tb_time_set_ctrl;

    localparam int DB = 4;
    localparam int BL = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_mode = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
    logic [4:0] cur_hour = '0;
    logic [5:0] cur_minute = '0, cur_second = '0;
    wire  [4:0] set_hour;
    wire  [5:0] set_minute, set_second;
    wire        load, hold, blink_on;
    wire  [1:0] edit_sel;

    time_set_ctrl #(.DB_CYCLES(DB), .BLINK_CYCLES(BL)) dut (
        .clk(clk), .rst(rst),
        .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down),
        .cur_hour(cur_hour), .cur_minute(cur_minute), .cur_second(cur_second),
        .set_hour(set_hour), .set_minute(set_minute), .set_second(set_second),
        .load(load), .hold(hold), .edit_sel(edit_sel), .blink_on(blink_on));

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] h;
        logic [5:0] m;
        logic [5:0] s;
        logic [1:0] sel;
        logic       hold;
        logic       load;
    } snap_t;

    snap_t obs;
    assign obs = {set_hour, set_minute, set_second, edit_sel, hold, load};

    snap_t exp_q[$];
    int    tests = 0;
    int    fails = 0;
    int    load_cycles = 0;
    logic  mon_en = 1'b0;

    // Monitor: every change of the observed outputs consumes one expected snapshot.
    initial begin
        snap_t prev, e;
        prev = '0;
        wait (mon_en);
        forever begin
            @(negedge clk);
            if (load) load_cycles++;
            if (obs != prev) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL snap_unexpected: got %0d:%0d:%0d sel=%0d hold=%0b load=%0b, required no change",
                             obs.h, obs.m, obs.s, obs.sel, obs.hold, obs.load);
                end else begin
                    e = exp_q.pop_front();
                    if (obs !== e) begin
                        fails++;
                        $display("FAIL snap: got %0d:%0d:%0d sel=%0d hold=%0b load=%0b, required %0d:%0d:%0d sel=%0d hold=%0b load=%0b",
                                 obs.h, obs.m, obs.s, obs.sel, obs.hold, obs.load,
                                 e.h, e.m, e.s, e.sel, e.hold, e.load);
                    end
                end
                prev = obs;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int h, input int m, input int s, input int sel,
                        input logic hd, input logic ld);
        snap_t e;
        e.h = 5'(h); e.m = 6'(m); e.s = 6'(s); e.sel = 2'(sel); e.hold = hd; e.load = ld;
        exp_q.push_back(e);
    endtask

    task automatic press(input logic m, input logic u, input logic d, input int hi = 10);
        btn_mode = m; btn_up = u; btn_down = d;
        cyc(hi);
        btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
        cyc(12);
    endtask

    task automatic check(input string nm, input int got, input int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", nm, got, want);
        end
    endtask

    initial begin
        bit found;
        cyc(3);
        check("rst_hour", int'(set_hour), 0);
        check("rst_min", int'(set_minute), 0);
        check("rst_sec", int'(set_second), 0);
        check("rst_sel", int'(edit_sel), 0);
        check("rst_hold", int'(hold), 0);
        check("rst_load", int'(load), 0);
        check("rst_blink", int'(blink_on), 1);
        rst = 1'b0;
        mon_en = 1'b1;
        cyc(2);

        // Full edit 12:34:56 -> 14:33:56 with bounce and up+down rejection
        cur_hour = 5'd12; cur_minute = 6'd34; cur_second = 6'd56;
        push(12, 34, 56, 1, 1, 0); press(1, 0, 0);
        press(0, 1, 0, 3);
        push(13, 34, 56, 1, 1, 0); press(0, 1, 0);
        push(14, 34, 56, 1, 1, 0); press(0, 1, 0);
        push(14, 34, 56, 2, 1, 0); press(1, 0, 0);
        press(0, 1, 1);
        push(14, 33, 56, 2, 1, 0); press(0, 0, 1);
        push(14, 33, 56, 3, 1, 0); press(1, 0, 0);
        push(14, 33, 56, 0, 1, 1);
        push(14, 33, 56, 0, 0, 0); press(1, 0, 0);

        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("run_blink", int'(blink_on), 1);
            check("run_sel", int'(edit_sel), 0);
        end
        press(0, 1, 0);
        press(0, 0, 1);

        // Wrap-around and mode-beats-up
        cur_hour = 5'd23; cur_minute = 6'd0; cur_second = 6'd59;
        push(23, 0, 59, 1, 1, 0); press(1, 0, 0);
        push(0, 0, 59, 1, 1, 0);  press(0, 1, 0);
        push(0, 0, 59, 2, 1, 0);  press(1, 1, 0);
        push(0, 59, 59, 2, 1, 0); press(0, 0, 1);

        // Blink in EDIT_S, measured from the entry cycle
        push(0, 59, 59, 3, 1, 0);
        btn_mode = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (edit_sel == 2'd3) found = 1'b1;
        end
        check("edit_s_reached", int'(found), 1);
        for (int k = 0; k < 24; k++) begin
            if (k > 0) @(negedge clk);
            check("blink_idle", int'(blink_on), ((k / 8) % 2 == 0) ? 1 : 0);
            if (k == 9) btn_mode = 1'b0;
        end

        push(0, 59, 0, 3, 1, 0);
        btn_up = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (set_second == 6'd0) found = 1'b1;
        end
        check("sec_wrap_seen", int'(found), 1);
        for (int k = 0; k < 12; k++) begin
            if (k > 0) @(negedge clk);
            check("blink_restart", int'(blink_on), (k < 8) ? 1 : 0);
            if (k == 4) btn_up = 1'b0;
        end
        cyc(12);
        push(0, 59, 0, 0, 1, 1);
        push(0, 59, 0, 0, 0, 0); press(1, 0, 0);

        // Reset mid-edit: no load, shadow cleared
        cur_hour = 5'd5; cur_minute = 6'd6; cur_second = 6'd7;
        push(5, 6, 7, 1, 1, 0); press(1, 0, 0);
        push(5, 6, 7, 2, 1, 0); press(1, 0, 0);
        push(0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_sel", int'(edit_sel), 0);
        check("mid_rst_hold", int'(hold), 0);
        check("mid_rst_load", int'(load), 0);
        check("mid_rst_hour", int'(set_hour), 0);
        check("mid_rst_blink", int'(blink_on), 1);
        cyc(2);
        rst = 1'b0;
        cyc(20);

        check("queue_drained", exp_q.size(), 0);
        check("load_cycles", load_cycles, 2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
